// File: rtl/aes_core_arbiter_pkg.sv
// Shared types and constants for the AES core arbiter.
// Holds the FSM encoding, block width and default timeout.
package aes_core_arbiter_pkg;

  localparam int BLOCK_W = 128;
  localparam int TIMEOUT_DEFAULT = 64;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_FLUSH,
    ST_RESP
  } state_t;

endpackage

// File: rtl/aes_core_arbiter_rr_grant.sv
// Two-way round-robin grant for the AES core arbiter.
// On a tie the requester not granted last time wins.
module aes_rr_grant (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic       accept,
  output logic       grant_id,
  output logic       grant_any
);

  logic last_grant;

  // pick the granted requester from the current requests
  always_comb begin
    grant_any = |req_valid;
    grant_id  = 1'b0;
    unique case (1'b1)
      (req_valid == 2'b11): grant_id = ~last_grant;
      (req_valid == 2'b10): grant_id = 1'b1;
      default:              grant_id = 1'b0;
    endcase
  end

  // remember who won the last accepted job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Arbitrates two requesters onto one shared AES core.
// Starts the core, waits with timeout, and returns a response.
module aes_core_arbiter
  import aes_core_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  block_t       req0_plain_text,
  input  block_t       req1_plain_text,
  input  block_t       req0_key,
  input  block_t       req1_key,
  output block_t       core_plain_text,
  output block_t       core_key,
  output logic         core_encrypt,
  output logic         core_reset,
  input  logic         core_done,
  input  block_t       core_data_out,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output block_t       resp_data,
  output logic         resp_error
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  block_t     cap_pt;
  block_t     cap_key;
  logic       cap_id;
  logic [7:0] cnt;
  logic       grant_id;
  logic       grant_any;
  logic       idle_ok;
  logic       accept;

  aes_rr_grant u_grant (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .accept    (accept),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  // ready only in IDLE, only for the granted requester
  always_comb begin
    idle_ok   = rst_n && (state == ST_IDLE) && grant_any;
    req_ready = {idle_ok && grant_id, idle_ok && !grant_id};
    accept    = |(req_valid & req_ready);
  end

  assign core_plain_text = cap_pt;
  assign core_key        = cap_key;

  // job sequencing: accept, start, wait/timeout, respond
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cap_pt       <= '0;
      cap_key      <= '0;
      cap_id       <= 1'b0;
      cnt          <= '0;
      core_encrypt <= 1'b0;
      core_reset   <= 1'b1;
      resp_valid   <= 1'b0;
      resp_id      <= 1'b0;
      resp_data    <= '0;
      resp_error   <= 1'b0;
    end else begin
      core_encrypt <= 1'b0;
      core_reset   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_pt       <= grant_id ? req1_plain_text : req0_plain_text;
            cap_key      <= grant_id ? req1_key : req0_key;
            cap_id       <= grant_id;
            core_encrypt <= 1'b1;
            state        <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            resp_data  <= core_data_out;
            resp_error <= 1'b0;
            resp_id    <= cap_id;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else if (cnt == TIMEOUT_LAST) begin
            core_reset <= 1'b1;
            state      <= ST_FLUSH;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_FLUSH: begin
          resp_data  <= '0;
          resp_error <= 1'b1;
          resp_id    <= cap_id;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_core_arbiter.md
AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL set the max WAIT cycles before abort; legal range 2..255.
REQ-002 clock  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester request; bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept, combinational: bit i high only in IDLE when requester i holds grant.
REQ-006 req0_plain_text, req1_plain_text  input  128 each  plaintext per requester.
REQ-007 req0_key, req1_key  input  128 each  key per requester.
REQ-008 core_plain_text, core_key  output  128 each  operands to shared AES encryption core.
REQ-009 core_encrypt  output  1  one-cycle start pulse to core.
REQ-010 core_reset  output  1  active-high core reset.
REQ-011 core_done  input  1  core completion flag.
REQ-012 core_data_out  input  128  core ciphertext.
REQ-013 resp_valid  output  1  response available.
REQ-014 resp_ready  input  1  consumer accepts response.
REQ-015 resp_id  output  1  requester index owning response.
REQ-016 resp_data  output  128  ciphertext.
REQ-017 resp_error  output  1  high when response is a timeout abort.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, WAIT, FLUSH, RESP.
REQ-019 Grant: one requester valid -> it; both valid -> the one not in last_grant; last_grant SHALL update on each accept.
REQ-020 Accept (req_valid[i] & req_ready[i] in IDLE) SHALL capture operands and index into registers and move to LOAD.
REQ-021 LOAD SHALL assert core_encrypt exactly one cycle, then enter WAIT with timeout counter cleared.
REQ-022 core_plain_text/core_key SHALL present captured operands, held stable from LOAD through WAIT.
REQ-023 WAIT: core_done high at a clock edge SHALL capture core_data_out into resp_data, clear resp_error, enter RESP.
REQ-024 WAIT: counter SHALL increment per cycle; reaching TIMEOUT_CYCLES with core_done low SHALL enter FLUSH.
REQ-025 core_done and timeout on the same edge SHALL resolve as done (no error).
REQ-026 FLUSH SHALL assert core_reset exactly one cycle, set resp_data=0, resp_error=1, then enter RESP.
REQ-027 RESP SHALL hold resp_valid, resp_id, resp_data, resp_error stable until resp_ready, then return to IDLE.
REQ-028 core_done outside WAIT SHALL be ignored; req_valid outside IDLE SHALL not be accepted.
REQ-029 Minimum accept-to-resp_valid latency SHALL be 3 cycles (LOAD, one WAIT edge with core_done, RESP).
REQ-030 Back-to-back: IDLE entered after a RESP handshake may accept on that same cycle's successor only (one IDLE cycle minimum between jobs).

Reset
REQ-031 While reset low: state IDLE, last_grant=1 (requester 0 wins first tie), counter 0, all captured registers 0.
REQ-032 While reset low: req_ready=0, core_encrypt=0, core_reset=1, resp_valid=0, resp_id=0, resp_data=0, resp_error=0, core_plain_text=core_key=0.
REQ-033 Reset assertion mid-operation SHALL abort immediately with no response emitted.

Structure
REQ-034 Shared package SHALL hold the state encoding, 128-bit block width constant and default TIMEOUT_CYCLES.
REQ-035 One sub-module, aes_rr_grant (two-way round-robin grant with last_grant register), is natural; rest is flat.

Verification
REQ-036 Single req0, key=plain=128'h49206c6f76652063686f636f6c617465, model core done after 10 cycles returning 128'h0123456789abcdeffedcba9876543210 -> one core_encrypt pulse, resp_valid with resp_id=0, that data, resp_error=0.
REQ-037 req0 and req1 both valid from reset -> grants order 0,1,0,1 over four jobs, each response id matching.
REQ-038 Core never asserts done, TIMEOUT_CYCLES=8 -> core_reset one-cycle pulse after 8 WAIT cycles, resp_error=1, resp_data=0.
REQ-039 resp_ready held low 5 cycles in RESP -> outputs stable, no new req_ready until handshake.
REQ-040 reset low during WAIT -> all outputs at reset values same cycle, core_reset=1, no resp_valid afterwards.
REQ-041 core_done coincident with timeout edge -> normal response, resp_error=0, no core_reset pulse.
